// File: rtl/cpu_result_tx.sv
// cpu_result_tx: serializes an ALU result byte plus four status flags as one
// framed symbol stream (start marker, 12 data symbols, optional parity, done).
// Each symbol is held for BIT_CYCLES clock cycles. Data order on tx_bit_o:
// result[7]..result[0], then c, z, v, n (flags_i[0]..flags_i[3]).
// Optional feature: define CPU_RESULT_TX_PARITY_EN to append an even-parity
// symbol over the 12 data bits between the last data symbol and DONE.
module cpu_result_tx #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       send_i,
  input  logic [7:0] result_i,
  input  logic [3:0] flags_i,
  output logic       tx_start_o,
  output logic       tx_bit_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef CPU_RESULT_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [7:0] LAST_CYC = 8'(BIT_CYCLES - 1);

`ifdef CPU_RESULT_TX_PARITY_EN
  // Even parity: the transmitted bit makes the total count of ones even.
  function automatic logic even_parity12(input logic [11:0] d);
    return ^d;
  endfunction
`endif

  state_e      state_q;
  logic [11:0] shreg_q;
  logic [7:0]  cyc_q;
  logic [3:0]  bit_q;
  logic        tx_start_q;
  logic        tx_bit_q;
  logic        busy_q;
  logic        done_q;
  logic [11:0] frame_d;
`ifdef CPU_RESULT_TX_PARITY_EN
  logic        par_q;
`endif

  // Arrange the captured frame so the MSB is always the next symbol to send.
  always_comb begin
    frame_d = {result_i, flags_i[0], flags_i[1], flags_i[2], flags_i[3]};
  end

  // Frame FSM: state, counters, shift register and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      shreg_q    <= 12'd0;
      cyc_q      <= 8'd0;
      bit_q      <= 4'd0;
      tx_start_q <= 1'b0;
      tx_bit_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CPU_RESULT_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (send_i) begin
            shreg_q    <= frame_d;
`ifdef CPU_RESULT_TX_PARITY_EN
            par_q      <= even_parity12(frame_d);
`endif
            cyc_q      <= 8'd0;
            bit_q      <= 4'd0;
            state_q    <= ST_START;
            tx_start_q <= 1'b1;
            tx_bit_q   <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end else begin
            tx_start_q <= 1'b0;
            tx_bit_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
          end
        end
        ST_START: begin
          if (cyc_q == LAST_CYC) begin
            cyc_q      <= 8'd0;
            state_q    <= ST_DATA;
            tx_start_q <= 1'b0;
            tx_bit_q   <= shreg_q[11];
          end else begin
            cyc_q <= cyc_q + 8'd1;
          end
        end
        ST_DATA: begin
          if (cyc_q == LAST_CYC) begin
            cyc_q <= 8'd0;
            if (bit_q == 4'd11) begin
              bit_q    <= 4'd0;
`ifdef CPU_RESULT_TX_PARITY_EN
              state_q  <= ST_PARITY;
              tx_bit_q <= par_q;
`else
              state_q  <= ST_DONE;
              tx_bit_q <= 1'b0;
              done_q   <= 1'b1;
`endif
            end else begin
              bit_q    <= bit_q + 4'd1;
              shreg_q  <= {shreg_q[10:0], 1'b0};
              tx_bit_q <= shreg_q[10];
            end
          end else begin
            cyc_q <= cyc_q + 8'd1;
          end
        end
`ifdef CPU_RESULT_TX_PARITY_EN
        ST_PARITY: begin
          if (cyc_q == LAST_CYC) begin
            cyc_q    <= 8'd0;
            state_q  <= ST_DONE;
            tx_bit_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cyc_q <= cyc_q + 8'd1;
          end
        end
`endif
        ST_DONE: begin
          state_q    <= ST_IDLE;
          tx_start_q <= 1'b0;
          tx_bit_q   <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          cyc_q      <= 8'd0;
          bit_q      <= 4'd0;
          tx_start_q <= 1'b0;
          tx_bit_q   <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_bit_o   = tx_bit_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_cpu_result_tx.sv
// Bench for cpu_result_tx: two instances (BIT_CYCLES=1 and 4), a per-cycle
// expected-output scoreboard per instance, table-driven frames plus
// hand-written sequences for ignored send, back-to-back and mid-frame reset.
module tb_cpu_result_tx;

`ifdef CPU_RESULT_TX_PARITY_EN
  localparam int SYMS = 14;
`else
  localparam int SYMS = 13;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic s1 = 1'b0, s4 = 1'b0;
  logic [7:0] r1 = 8'h00, r4 = 8'h00;
  logic [3:0] f1 = 4'h0, f4 = 4'h0;
  logic st1, b1, bz1, d1, st4, b4, bz4, d4;

  int n_err = 0;
  int n_chk = 0;

  // Expected {tx_start, tx_bit, busy, done} per sampled cycle.
  logic [3:0] q1[$];
  logic [3:0] q4[$];

  typedef struct {
    logic [7:0]  res;
    logic [3:0]  flg;
    int          sel;
    logic [11:0] bits;  // serial order, bits[11] sent first
    logic        par;
  } vec_t;
  vec_t vecs[6];

  cpu_result_tx #(.BIT_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .send_i(s1), .result_i(r1), .flags_i(f1),
    .tx_start_o(st1), .tx_bit_o(b1), .busy_o(bz1), .done_o(d1));

  cpu_result_tx #(.BIT_CYCLES(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_ni), .send_i(s4), .result_i(r4), .flags_i(f4),
    .tx_start_o(st4), .tx_bit_o(b4), .busy_o(bz4), .done_o(d4));

  always #5 clk = ~clk;

  function automatic logic [3:0] outs(input int sel);
    return (sel == 4) ? {st4, b4, bz4, d4} : {st1, b1, bz1, d1};
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 4) ? q4.size() : q1.size();
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: start/bit/busy/done got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int sel, input logic [3:0] v);
    if (sel == 4) q4.push_back(v);
    else q1.push_back(v);
  endtask

  task automatic push_frame(input int sel, input logic [11:0] bits, input logic par);
    for (int c = 0; c < sel; c++) push(sel, 4'b1010);
    for (int i = 11; i >= 0; i--)
      for (int c = 0; c < sel; c++) push(sel, {1'b0, bits[i], 1'b1, 1'b0});
`ifdef CPU_RESULT_TX_PARITY_EN
    for (int c = 0; c < sel; c++) push(sel, {1'b0, par, 1'b1, 1'b0});
`else
    if (par === 1'bx) push(sel, 4'b0000);  // never true: par is always 0/1
`endif
    push(sel, 4'b0011);
    push(sel, 4'b0000);
  endtask

  task automatic set_send(input int sel, input logic v);
    if (sel == 4) s4 = v;
    else s1 = v;
  endtask

  task automatic set_data(input int sel, input logic [7:0] r, input logic [3:0] f);
    if (sel == 4) begin r4 = r; f4 = f; end
    else begin r1 = r; f1 = f; end
  endtask

  // Compare every cycle until the scoreboard drains. pulse_k: cycle after
  // which send is pulsed with result 00; hold_k: send held while k<hold_k.
  task automatic drain(input int sel, input int pulse_k, input int hold_k,
                       input int exp_busy, input string nm);
    int k;
    int busy_n;
    logic [3:0] e;
    k = 0;
    busy_n = 0;
    while (qsize(sel) > 0 && k < 400) begin
      @(negedge clk);
      if (outs(sel)[1]) busy_n++;
      if (sel == 4) e = q4.pop_front();
      else e = q1.pop_front();
      chk(nm, outs(sel), e);
      set_send(sel, (k == pulse_k) || (k < hold_k));
      if (k == pulse_k) set_data(sel, 8'h00, 4'h0);
      else if (k >= hold_k) set_data(sel, 8'($urandom), 4'($urandom));
      k++;
    end
    set_send(sel, 1'b0);
    if (qsize(sel) > 0) begin
      n_chk++; n_err++;
      $display("FAIL %s_timeout: %0d records left, required 0", nm, qsize(sel));
    end
    if (exp_busy >= 0) begin
      n_chk++;
      if (busy_n != exp_busy) begin
        n_err++;
        $display("FAIL %s_busy_len: got %0d cycles required %0d", nm, busy_n, exp_busy);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 4'b0101, 1, 12'b1010_0101_1010, 1'b0};
    vecs[1] = '{8'hFF, 4'hF,    4, 12'hFFF,            1'b0};
    vecs[2] = '{8'h00, 4'h0,    1, 12'h000,            1'b0};
    vecs[3] = '{8'h3C, 4'b0001, 1, 12'b0011_1100_1000, 1'b1};
    vecs[4] = '{8'h81, 4'b1000, 1, 12'b1000_0001_0001, 1'b1};
    vecs[5] = '{8'h5A, 4'b0110, 4, 12'b0101_1010_0110, 1'b0};

    // Reset forces outputs low without any clock edge.
    #1 rst_ni = 1'b0;
    #1;
    chk("reset_dut1", outs(1), 4'b0000);
    chk("reset_dut4", outs(4), 4'b0000);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      set_data(vecs[v].sel, vecs[v].res, vecs[v].flg);
      set_send(vecs[v].sel, 1'b1);
      push_frame(vecs[v].sel, vecs[v].bits, vecs[v].par);
      drain(vecs[v].sel, -1, 0, SYMS * vecs[v].sel + 1, $sformatf("vec%0d", v));
    end

    // send pulsed with result 00 during data symbol 5: ignored.
    @(negedge clk);
    set_data(1, 8'hA5, 4'b0101);
    set_send(1, 1'b1);
    push_frame(1, 12'b1010_0101_1010, 1'b0);
    drain(1, 5, 0, SYMS + 1, "ignore_send");

    // send held across DONE: one idle cycle, then a second frame.
    @(negedge clk);
    set_data(1, 8'h81, 4'b1000);
    set_send(1, 1'b1);
    push_frame(1, 12'b1000_0001_0001, 1'b1);
    push_frame(1, 12'b1000_0001_0001, 1'b1);
    drain(1, -1, SYMS + 2, -1, "back_to_back");

    // Reset in the middle of a frame, then a fresh frame.
    @(negedge clk);
    set_data(1, 8'hA5, 4'b0101);
    set_data(4, 8'hA5, 4'b0101);
    set_send(1, 1'b1);
    set_send(4, 1'b1);
    @(negedge clk);
    set_send(1, 1'b0);
    set_send(4, 1'b0);
    repeat (7) @(negedge clk);
    #2;
    chk("midframe_dut1", outs(1), 4'b0010);
    chk("midframe_dut4", outs(4), 4'b0110);
    rst_ni = 1'b0;
    #1;
    chk("midrst_dut1", outs(1), 4'b0000);
    chk("midrst_dut4", outs(4), 4'b0000);
    @(negedge clk);
    rst_ni = 1'b1;
    push(1, 4'b0000);
    push(1, 4'b0000);
    drain(1, -1, 0, -1, "post_rst_idle");
    @(negedge clk);
    set_data(1, 8'h3C, 4'b0001);
    set_send(1, 1'b1);
    push_frame(1, 12'b0011_1100_1000, 1'b1);
    drain(1, -1, 0, SYMS + 1, "post_rst_frame");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
